// File: rtl/fp_adder_pipelined.sv
// Three-stage floating-point adder/subtractor: align, add, normalise/round.
// Denormals flush to zero; specials are resolved in the align stage.
module fp_adder_pipelined #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic [EXP_W+MAN_W:0] i_Addend1,
  input  logic [EXP_W+MAN_W:0] i_Addend2,
  input  logic                 i_Sub,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic [EXP_W+MAN_W:0] o_Sum,
  output logic [2:0]           o_Flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;
  localparam int SW = MAN_W + 5;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic             sub;
    logic [MW-1:0]    a;
    logic [MW-1:0]    b;
    logic             spec;
    logic [W-1:0]     sval;
    logic [2:0]       sflg;
  } s1_t;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
    logic             spec;
    logic [W-1:0]     sval;
    logic [2:0]       sflg;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic v1, v2, en;
  logic [W-1:0] res;
  logic [2:0] flg;

  assign o_Ready = ~o_Valid | i_Ready;
  assign en = o_Ready;

  logic sa, sb, za, zb, na, nb, ia, ib, swp;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [MAN_W-1:0] ma, mb;
  logic [MAN_W:0] ha, hb, hl, hs;
  logic [2*MAN_W+3:0] wide;

  always_comb begin
    sa = i_Addend1[W-1];
    ea = i_Addend1[W-2:MAN_W];
    ma = i_Addend1[MAN_W-1:0];
    sb = i_Addend2[W-1] ^ i_Sub;
    eb = i_Addend2[W-2:MAN_W];
    mb = i_Addend2[MAN_W-1:0];
    za = ea == '0;
    zb = eb == '0;
    na = (ea == EMAX) && (ma != '0);
    nb = (eb == EMAX) && (mb != '0);
    ia = (ea == EMAX) && (ma == '0);
    ib = (eb == EMAX) && (mb == '0);
    ha = za ? '0 : {1'b1, ma};
    hb = zb ? '0 : {1'b1, mb};
    swp = {eb, hb} > {ea, ha};
    el = swp ? eb : ea;
    es = swp ? ea : eb;
    hl = swp ? hb : ha;
    hs = swp ? ha : hb;
    d = el - es;
    wide = {hs, {(MAN_W+3){1'b0}}} >> d;
    s1_d = '0;
    s1_d.sgn = swp ? sb : sa;
    s1_d.exp = el;
    s1_d.sub = sa ^ sb;
    s1_d.a = {hl, 3'b000};
    // far-shifted operand only survives as sticky
    if (int'(d) >= MAN_W + 3)
      s1_d.b = {{(MW-1){1'b0}}, |hs};
    else
      s1_d.b = {wide[2*MAN_W+3:MAN_W+1], |wide[MAN_W:0]};
    if (na | nb) begin
      s1_d.spec = 1'b1;
      s1_d.sval = QNAN;
    end else if (ia & ib & (sa ^ sb)) begin
      s1_d.spec = 1'b1;
      s1_d.sval = QNAN;
      s1_d.sflg = 3'b100;
    end else if (ia) begin
      s1_d.spec = 1'b1;
      s1_d.sval = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (ib) begin
      s1_d.spec = 1'b1;
      s1_d.sval = {sb, EMAX, {MAN_W{1'b0}}};
    end else if (za & zb) begin
      s1_d.spec = 1'b1;
      s1_d.sval = {sa & sb, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    s2_d.sgn  = s1_q.sgn;
    s2_d.exp  = s1_q.exp;
    s2_d.spec = s1_q.spec;
    s2_d.sval = s1_q.sval;
    s2_d.sflg = s1_q.sflg;
    if (s1_q.sub)
      s2_d.sum = {1'b0, s1_q.a} - {1'b0, s1_q.b};
    else
      s2_d.sum = {1'b0, s1_q.a} + {1'b0, s1_q.b};
  end

  logic [MW-1:0] n;
  logic [MAN_W+1:0] mr;
  logic up;
  int ex, lz;

  always_comb begin
    lz = MW;
    for (int i = 0; i < MW; i++)
      if (s2_q.sum[i]) lz = MW - 1 - i;
    ex = int'(s2_q.exp);
    if (s2_q.sum[SW-1]) begin
      n = s2_q.sum[SW-1:1];
      n[0] = s2_q.sum[1] | s2_q.sum[0];
      ex = ex + 1;
    end else begin
      n = s2_q.sum[MW-1:0] << lz;
      ex = ex - lz;
    end
    up = n[2] & (n[3] | n[1] | n[0]);
    mr = {1'b0, n[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    if (mr[MAN_W+1]) begin
      mr = mr >> 1;
      ex = ex + 1;
    end
    res = {s2_q.sgn, ex[EXP_W-1:0], mr[MAN_W-1:0]};
    flg = {2'b00, |n[2:0]};
    if (s2_q.spec) begin
      res = s2_q.sval;
      flg = s2_q.sflg;
    end else if (s2_q.sum == '0) begin
      res = '0;
      flg = '0;
    end else if (ex >= int'(EMAX)) begin
      res = {s2_q.sgn, EMAX, {MAN_W{1'b0}}};
      flg = 3'b011;
    end else if (ex <= 0) begin
      res = {s2_q.sgn, {(W-1){1'b0}}};
      flg = 3'b001;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      o_Valid <= 1'b0;
      o_Sum   <= '0;
      o_Flags <= '0;
    end else if (en) begin
      v1      <= i_Valid;
      v2      <= v1;
      o_Valid <= v2;
      if (i_Valid) s1_q <= s1_d;
      if (v1) s2_q <= s2_d;
      if (v2) begin
        o_Sum   <= res;
        o_Flags <= flg;
      end
    end
  end

endmodule
